bmc_cell_sampler: RTL and testbench
===================================

Name: bmc_cell_sampler

Overview:
Receive front-end for the optical link. It oversamples the asynchronous photodetector comparator output and locks onto Biphase Mark transitions. Once locked, it emits one recovered half-bit cell level per valid pulse. Its outputs drive bmc_decoder directly: o_cell feeds i_block and o_valid feeds valid_in.

Parameters:
OSR, 8, clk samples per BMC half-bit cell; even, ≥4.
TOL, 2, allowed ± sample deviation on an edge gap; must satisfy TOL < OSR/2.
LOCK_EDGES, 4, consecutive in-spec edge gaps required to enter LOCKED.
CNT_W, $clog2(2*OSR+TOL+2), width of the gap counter (derived; do not override).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
rx_in  in  1  raw comparator output; asynchronous to clk.
o_cell  out  1  recovered half-cell level, qualified by o_valid.
o_valid  out  1  single-cycle strobe; one per recovered half-cell.
o_locked  out  1  high while the FSM is in LOCKED.
o_err_cnt  out  8  saturating count of gap violations while LOCKED.

Behaviour:
- Reset (rst==0): sync flops=0, prev=0, cnt=0, good_cnt=0, state=HUNT, o_cell=0, o_valid=0, o_locked=0, o_err_cnt=0.
- Synchronizer: rx_in passes through 2 flops to give rx_s. Edge = (rx_s != prev), with prev registered. The edge is visible 3 clks after rx_in toggles.
- Gap counter cnt:
  - An edge cycle sets gap=cnt+1, then cnt<=0.
  - Otherwise cnt increments and saturates at 2*OSR+TOL+1.
- Gap classes:
  - SHORT: gap in [OSR-TOL, OSR+TOL].
  - LONG: gap in [2*OSR-TOL, 2*OSR+TOL].
  - Any other gap is BAD.
- Timeout: cnt reaching saturation with no edge.
- FSM states HUNT and LOCKED:
  - HUNT: on an edge with a SHORT or LONG gap, good_cnt++. On a BAD gap, good_cnt<=0.
  - HUNT → LOCKED when good_cnt reaches LOCK_EDGES. Timeout holds good_cnt at 0.
  - LOCKED → HUNT on a BAD gap or on timeout; good_cnt<=0 and o_err_cnt++ (saturating at 255).
  - The transition takes effect the next cycle.
- Cell emission (LOCKED only):
  - When cnt==OSR/2-1 or cnt==OSR+OSR/2-1 and no edge this cycle: o_valid<=1 and o_cell<=rx_s.
  - Result is 1 cell per SHORT gap and 2 cells per LONG gap.
- Edge and emission in the same cycle: the edge wins, no emission, and cnt resets.
- o_valid is never asserted in HUNT, including the cycle of the HUNT→LOCKED transition. The first emission follows the first qualifying edge after lock.
- o_locked is registered and mirrors the state.
- o_err_cnt only changes in LOCKED. Errors in HUNT are not counted.
- Mid-stream reset: all outputs return to reset values at the next posedge. No emission occurs in the reset cycle or the following cycle.

Decomposition:
- Package bmc_pkg:
  - state_t enum {HUNT, LOCKED}.
  - gap_class_t enum {GAP_SHORT, GAP_LONG, GAP_BAD}.
  - Default OSR and TOL localparams, shared with bmc_decoder-side benches.
- One sub-module: sync_2ff, a generic 2-flop synchronizer (width-parameterized, reset to 0). The gap classifier stays inline as a function.

Test Plan:
- OSR=8, TOL=2. Drive a BMC stream for 0xA5A5 (no jitter), one sample per clk → o_locked high after 4 edges. The o_cell pairs then decode to the remaining bits, with o_valid spaced exactly 8 clks apart.
- ±2-sample jitter on every edge → lock is held, o_err_cnt stays 0, and no cell is dropped or duplicated.
- While locked, inject a 3-sample glitch pulse (gap=3) → the next cycle has o_locked=0 and o_err_cnt=1, o_valid stays 0 in HUNT, and the block relocks after 4 good gaps.
- While locked, hold rx_in constant for 20 clks → timeout at cnt=19, o_locked drops, and o_err_cnt increments by 1.
- Force 260 BAD-gap relock cycles → o_err_cnt saturates at 255 and does not wrap.
- Assert rst=0 for 1 cycle mid-frame → all outputs read 0 the next cycle, and the block relocks from HUNT.

Source files
------------

// File: rtl/bmc_pkg.sv
// Shared types and defaults for the optical-link BMC receive path.
// Used by bmc_cell_sampler and by the bmc_decoder-side benches.
package bmc_pkg;

  localparam int OSR_DEF = 8;
  localparam int TOL_DEF = 2;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    GAP_SHORT,
    GAP_LONG,
    GAP_BAD
  } gap_class_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, width-parameterized, sync active-low reset.
// Ports: clk, rst (active low), d (async input), q (synchronized output).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bmc_cell_sampler.sv
// Oversampling BMC receive front-end: locks to edge gaps, emits half-cells.
// Ports: clk, rst (sync active low), rx_in (async), o_cell/o_valid, o_locked, o_err_cnt.
module bmc_cell_sampler
  import bmc_pkg::*;
#(
  parameter int OSR        = OSR_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_EDGES = 4,
  parameter int CNT_W      = $clog2(2*OSR+TOL+2)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       o_cell,
  output logic       o_valid,
  output logic       o_locked,
  output logic [7:0] o_err_cnt
);

  localparam int CNT_MAX = 2*OSR + TOL + 1;
  // gap = cnt+1 may need one bit more than cnt
  localparam int GW      = CNT_W + 1;
  localparam int GOOD_W  = $clog2(LOCK_EDGES + 1);

  function automatic gap_class_t classify(input logic [GW-1:0] g);
    int gi;
    gi = int'(g);
    classify = GAP_BAD;
    unique case (1'b1)
      (gi >= OSR-TOL && gi <= OSR+TOL):
        classify = GAP_SHORT;
      (gi >= 2*OSR-TOL && gi <= 2*OSR+TOL):
        classify = GAP_LONG;
      default:
        classify = GAP_BAD;
    endcase
  endfunction

  logic              rx_s;
  logic              prev;
  logic              edge_det;
  logic [CNT_W-1:0]  cnt;
  logic [GW-1:0]     gap;
  gap_class_t        gclass;
  logic              timeout;
  logic              emit_pt;
  state_t            state;
  logic [GOOD_W-1:0] good_cnt;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign edge_det = (rx_s != prev);
  assign gap      = GW'(cnt) + GW'(1);
  assign gclass   = classify(gap);
  assign timeout  = !edge_det && (cnt == CNT_W'(CNT_MAX));
  // sample points at the middle of the first and second half-cell
  assign emit_pt  = (cnt == CNT_W'(OSR/2 - 1)) ||
                    (cnt == CNT_W'(OSR + OSR/2 - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= 1'b0;
      cnt       <= '0;
      good_cnt  <= '0;
      state     <= HUNT;
      o_cell    <= 1'b0;
      o_valid   <= 1'b0;
      o_locked  <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      prev    <= rx_s;
      o_valid <= 1'b0;

      if (edge_det)
        cnt <= '0;
      else if (cnt != CNT_W'(CNT_MAX))
        cnt <= cnt + CNT_W'(1);

      unique case (state)
        HUNT: begin
          if (edge_det && gclass != GAP_BAD) begin
            if (good_cnt == GOOD_W'(LOCK_EDGES - 1)) begin
              state    <= LOCKED;
              o_locked <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end else if (edge_det || timeout) begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if ((edge_det && gclass == GAP_BAD) || timeout) begin
            state    <= HUNT;
            o_locked <= 1'b0;
            good_cnt <= '0;
            if (o_err_cnt != 8'hFF)
              o_err_cnt <= o_err_cnt + 8'd1;
          end else if (!edge_det && emit_pt) begin
            o_valid <= 1'b1;
            o_cell  <= rx_s;
          end
        end
        default: begin
          state    <= HUNT;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmc_cell_sampler.sv
// Directed bench for bmc_cell_sampler: BMC streams from a table plus
// hand sequences for glitch, timeout, error saturation and mid-stream reset.
module tb_bmc_cell_sampler;
  import bmc_pkg::*;

  localparam int OSR = OSR_DEF;
  localparam int TOL = TOL_DEF;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       o_cell;
  logic       o_valid;
  logic       o_locked;
  logic [7:0] o_err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nv = 0;
  int exp_err = 0;
  logic cells[$];
  int   vcyc[$];

  typedef struct {
    logic [15:0] data;
    int          nbits;
    bit          jit;
    int          exp_cells;
  } vec_t;

  vec_t vecs[5];

  bmc_cell_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .o_cell    (o_cell),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_err_cnt (o_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_valid) begin
      nv++;
      cells.push_back(o_cell);
      vcyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic seg(input logic lvl, input int len);
    rx_in = lvl;
    idle(len);
  endtask

  task automatic lock_up(input string name);
    repeat (5) seg(~rx_in, OSR);
    chk(name, int'(o_locked), 1);
  endtask

  task automatic send_stream(input int idx, input vec_t v);
    logic h[$];
    logic lvls[$];
    int   lens[$];
    logic expq[$];
    logic lvl;
    int   len;
    int   nm;
    int   ns;
    int   last;
    lvl = rx_in;
    for (int i = v.nbits - 1; i >= 0; i--) begin
      lvl = ~lvl;
      h.push_back(lvl);
      if (v.data[i]) lvl = ~lvl;
      h.push_back(lvl);
    end
    for (int i = 0; i < h.size(); i++) begin
      if (i == 0 || h[i] != h[i-1]) begin
        lens.push_back(1);
        lvls.push_back(h[i]);
      end else begin
        lens[lens.size()-1] = lens[lens.size()-1] + 1;
      end
    end
    last = lens.size() - 1;
    // first edge follows idle (bad), lock lands on the edge of segment 4
    for (int k = 4; k <= last; k++) begin
      repeat (lens[k]) expq.push_back(lvls[k]);
      if (k == last && lens[k] == 1) expq.push_back(lvls[k]);
    end
    cells.delete();
    vcyc.delete();
    for (int k = 0; k <= last; k++) begin
      len = lens[k] * OSR;
      if (v.jit && k != last) len += (k % 2) ? -TOL : TOL;
      seg(lvls[k], len);
    end
    chk($sformatf("v%0d_locked", idx), int'(o_locked), 1);
    chk($sformatf("v%0d_err_hold", idx), int'(o_err_cnt), exp_err);
    idle(40);
    exp_err++;
    chk($sformatf("v%0d_unlock", idx), int'(o_locked), 0);
    chk($sformatf("v%0d_err_end", idx), int'(o_err_cnt), exp_err);
    chk($sformatf("v%0d_ncells", idx), cells.size(), v.exp_cells);
    nm = (cells.size() != expq.size()) ? 1 : 0;
    for (int i = 0; i < cells.size() && i < expq.size(); i++)
      if (cells[i] !== expq[i]) nm++;
    chk($sformatf("v%0d_cellvals", idx), nm, 0);
    if (!v.jit) begin
      ns = 0;
      for (int i = 1; i < vcyc.size(); i++)
        if (vcyc[i] - vcyc[i-1] != OSR) ns++;
      chk($sformatf("v%0d_spacing", idx), ns, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int nv0;
    vecs[0] = '{16'hA5A5, 16, 1'b0, 28};
    vecs[1] = '{16'hA5A5, 16, 1'b1, 28};
    vecs[2] = '{16'h00FF, 8, 1'b0, 13};
    vecs[3] = '{16'h0000, 8, 1'b0, 8};
    vecs[4] = '{16'h000F, 8, 1'b1, 9};

    rst   = 1'b0;
    rx_in = 1'b0;
    idle(3);
    chk("rst_cell", int'(o_cell), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_err", int'(o_err_cnt), 0);
    rst = 1'b1;
    idle(30);

    for (int i = 0; i < 5; i++) send_stream(i, vecs[i]);

    // 3-sample glitch while locked
    lock_up("gl_lock");
    seg(~rx_in, 3);
    rx_in = ~rx_in;
    idle(2);
    chk("gl_pre", int'(o_locked), 1);
    idle(1);
    exp_err++;
    chk("gl_drop", int'(o_locked), 0);
    chk("gl_err", int'(o_err_cnt), exp_err);
    nv0 = nv;
    idle(5);
    repeat (3) seg(~rx_in, OSR);
    chk("gl_hunt_quiet", nv - nv0, 0);
    chk("gl_hunt_still", int'(o_locked), 0);
    seg(~rx_in, OSR);
    chk("gl_relock", int'(o_locked), 1);
    idle(40);
    exp_err++;
    chk("gl_err2", int'(o_err_cnt), exp_err);

    // timeout: rx held constant after a good edge
    lock_up("to_lock");
    rx_in = ~rx_in;
    idle(22);
    chk("to_pre", int'(o_locked), 1);
    idle(1);
    exp_err++;
    chk("to_drop", int'(o_locked), 0);
    chk("to_err", int'(o_err_cnt), exp_err);
    idle(20);

    // 260 lock/bad cycles saturate the error counter
    seg(~rx_in, OSR);
    for (int c = 0; c < 260; c++) begin
      if (c == 10) chk("sat_mid", int'(o_err_cnt), exp_err + 9);
      repeat (4) seg(~rx_in, OSR);
      seg(~rx_in, 3);
    end
    rx_in = ~rx_in;
    idle(40);
    exp_err = 255;
    chk("sat_err", int'(o_err_cnt), exp_err);

    // single-cycle reset mid-frame
    lock_up("mr_lock");
    seg(~rx_in, 4);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    chk("mr_cell", int'(o_cell), 0);
    chk("mr_valid", int'(o_valid), 0);
    chk("mr_locked", int'(o_locked), 0);
    chk("mr_err", int'(o_err_cnt), 0);
    idle(1);
    chk("mr_valid2", int'(o_valid), 0);
    exp_err = 0;
    repeat (6) seg(~rx_in, OSR);
    chk("mr_relock", int'(o_locked), 1);
    idle(40);
    exp_err++;
    chk("mr_err_end", int'(o_err_cnt), exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
